// File: rtl/mole_pkg.sv
// mole_pkg: shared FSM state codes, LFSR constants and small helpers for mole_game_ctrl.
// Rev 1.0
`default_nettype none

package mole_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_SHOW   = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;

  localparam logic [15:0] C_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? C_LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mole_game_ctrl_btn_cond.sv
// btn_cond: 2-flop synchronizer, optional tick-based debounce (MOLE_DEBOUNCE_EN), rising-edge press pulses.
// Rev 1.0
`default_nettype none

module btn_cond #(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic [7:0] btn,
  output logic [7:0] press
);

  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_lvl_d;
  logic [7:0] w_lvl;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_lvl_d <= '0;
    end else begin
      r_s1    <= btn;
      r_s2    <= r_s1;
      r_lvl_d <= w_lvl;
    end
  end

`ifdef MOLE_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_db
      logic          r_db;
      logic [CW-1:0] r_cnt;

      // Count ticks while the synchronized level disagrees; any agreement restarts the count
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_db  <= 1'b0;
          r_cnt <= '0;
        end else if (r_s2[i] == r_db) begin
          r_cnt <= '0;
        end else if (tick) begin
          if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
            r_db  <= r_s2[i];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_lvl[i] = r_db;
    end
  endgenerate
`else
  logic w_unused_cfg;
  assign w_unused_cfg = tick ^ DEBOUNCE_MS[0];
  assign w_lvl        = r_s2;
`endif

  assign press = w_lvl & ~r_lvl_d;

endmodule

`default_nettype wire

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole round FSM, LFSR target pick, ms prescaler and score/miss/round counters.
// Optional button debounce under MOLE_DEBOUNCE_EN. Rev 1.0
`default_nettype none

module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int          TICK_CYCLES = 100000,
  parameter int          ROUND_MS    = 1000,
  parameter int          SHOW_MS     = 250,
  parameter int          GAME_ROUNDS = 30,
  parameter int          DEBOUNCE_MS = 10,
  parameter logic [15:0] LFSR_SEED   = C_DEFAULT_SEED
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] btn,
  output logic [7:0] random_num,
  output logic [7:0] hit,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic [7:0] round,
  output logic       game_over
);

  localparam int PW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int MS_MAX = (ROUND_MS > SHOW_MS) ? ROUND_MS : SHOW_MS;
  localparam int MW     = $clog2(MS_MAX + 1);

  logic [2:0]    r_state;
  logic [15:0]   r_lfsr;
  logic [2:0]    r_prev;
  logic [2:0]    r_idx;
  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_ms;
  logic          r_start_d;
  logic [7:0]    r_random;
  logic [7:0]    r_hit;
  logic [7:0]    r_score;
  logic [7:0]    r_misses;
  logic [7:0]    r_round;
  logic          r_over;

  logic       w_tick;
  logic [7:0] w_press;
  logic [2:0] w_raw;
  logic [2:0] w_pick;
  logic [7:0] w_target;
  logic       w_wrong;

  assign w_tick   = (r_pre == PW'(TICK_CYCLES - 1));
  assign w_raw    = r_lfsr[2:0];
  assign w_pick   = (w_raw == r_prev) ? w_raw + 3'd1 : w_raw;
  assign w_target = 8'd1 << r_idx;
  assign w_wrong  = |(w_press & ~w_target);

  btn_cond #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_btn_cond (
    .CLK   (CLK),
    .RST   (RST),
    .tick  (w_tick),
    .btn   (btn),
    .press (w_press)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_prev    <= '0;
      r_idx     <= '0;
      r_pre     <= '0;
      r_ms      <= '0;
      r_start_d <= 1'b0;
      r_random  <= '0;
      r_hit     <= '0;
      r_score   <= '0;
      r_misses  <= '0;
      r_round   <= '0;
      r_over    <= 1'b0;
    end else begin
      r_lfsr    <= lfsr_next(r_lfsr);
      r_start_d <= start;
      r_pre     <= w_tick ? '0 : r_pre + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_score  <= '0;
            r_misses <= '0;
            r_round  <= '0;
            r_state  <= ST_ARM;
          end
        end

        ST_ARM: begin
          r_idx    <= w_pick;
          r_prev   <= w_pick;
          r_random <= 8'd1 << w_pick;
          r_hit    <= '0;
          r_pre    <= '0;
          r_ms     <= '0;
          r_state  <= ST_ACTIVE;
        end

        // A correct press outranks both a simultaneous wrong press and timer expiry
        ST_ACTIVE: begin
          if (w_press[r_idx]) begin
            r_score  <= sat_inc(r_score);
            r_hit    <= w_target;
            r_random <= '0;
            r_pre    <= '0;
            r_ms     <= '0;
            r_state  <= ST_SHOW;
          end else if (w_tick && (r_ms == MW'(ROUND_MS - 1))) begin
            r_misses <= sat_inc(r_misses);
            r_hit    <= '0;
            r_random <= '0;
            r_pre    <= '0;
            r_ms     <= '0;
            r_state  <= ST_SHOW;
          end else begin
            if (w_wrong) r_misses <= sat_inc(r_misses);
            if (w_tick)  r_ms     <= r_ms + 1'b1;
          end
        end

        ST_SHOW: begin
          if (w_tick && (r_ms == MW'(SHOW_MS - 1))) begin
            r_round <= sat_inc(r_round);
            if (r_round + 8'd1 == 8'(GAME_ROUNDS)) begin
              r_over   <= 1'b1;
              r_hit    <= 8'hFF;
              r_random <= '0;
              r_state  <= ST_OVER;
            end else begin
              r_hit   <= '0;
              r_state <= ST_ARM;
            end
          end else if (w_tick) begin
            r_ms <= r_ms + 1'b1;
          end
        end

        ST_OVER: begin
          if (start && !r_start_d) begin
            r_score  <= '0;
            r_misses <= '0;
            r_round  <= '0;
            r_over   <= 1'b0;
            r_hit    <= '0;
            r_state  <= ST_ARM;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign random_num = r_random;
  assign hit        = r_hit;
  assign score      = r_score;
  assign misses     = r_misses;
  assign round      = r_round;
  assign game_over  = r_over;

endmodule

`default_nettype wire
